// File: rtl/fir3_tap_pkg.sv
// Shared types, default coefficients and saturation helpers for the 3-tap FIR.
package fir3_tap_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned SUM_W    = 17;
    localparam int unsigned PROD_W   = 32;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]    sum_t;
    typedef logic signed [PROD_W-1:0]   prod_t;

    localparam sample_t     C0_DEF          = 16'sd1;
    localparam sample_t     C1_DEF          = 16'sd2;
    localparam sample_t     C2_DEF          = 16'sd1;
    localparam int unsigned FRAC_DEF        = 2;
    localparam int unsigned APPROX_LSBS_DEF = 4;

    localparam prod_t SAT_MAX = 32'sd32767;
    localparam prod_t SAT_MIN = -32'sd32768;

    // Clamp a wide signed value into the 16-bit sample range.
    function automatic sample_t sat16(input prod_t v);
        if (v > SAT_MAX) begin
            return 16'sh7FFF;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end
        return 16'(v);
    endfunction

    // Full-precision product, arithmetic shift (floor), then saturate.
    function automatic sample_t scale_prod(input sample_t xs, input sample_t c,
                                           input int unsigned frac);
        prod_t m;
        m = prod_t'(xs) * prod_t'(c);
        return sat16(m >>> frac);
    endfunction

endpackage

// File: rtl/fir3_tap_add.sv
// Approximate signed adder: low bits ORed, upper part carries in from the top low bit.
module approx_add16
    import fir3_tap_pkg::*;
#(
    parameter int unsigned APPROX_LSBS = APPROX_LSBS_DEF
) (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [16:0] s
);

    generate
        if (APPROX_LSBS == 0) begin : g_exact
            assign s = SUM_W'(a) + SUM_W'(b);
        end else begin : g_approx
            localparam int unsigned K = APPROX_LSBS;
            logic cin;
            sum_t hi;
            sum_t low;

            assign cin = a[K-1] & b[K-1];
            // Upper part is kept shifted down so the 17-bit result never wraps.
            assign hi  = (SUM_W'(a) >>> K) + (SUM_W'(b) >>> K)
                       + $signed({(SUM_W-1)'(0), cin});
            assign low = SUM_W'(a[K-1:0] | b[K-1:0]);
            assign s   = (hi <<< K) | low;
        end
    endgenerate

endmodule

// File: rtl/fir3_tap.sv
// 3-tap direct-form FIR with approximate adders; one sample in and one out per clock.
module fir3_tap
    import fir3_tap_pkg::*;
#(
    parameter logic signed [15:0] C0          = C0_DEF,
    parameter logic signed [15:0] C1          = C1_DEF,
    parameter logic signed [15:0] C2          = C2_DEF,
    parameter int unsigned        FRAC        = FRAC_DEF,
    parameter int unsigned        APPROX_LSBS = APPROX_LSBS_DEF
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic signed [15:0] x,
    output logic signed [15:0] y
);

    sample_t x_d1_q;
    sample_t x_d2_q;
    sample_t y_q;
    sample_t y_d;

    sample_t p0_c;
    sample_t p1_c;
    sample_t p2_c;
    sum_t    s1_raw_c;
    sample_t s1_c;
    sum_t    s2_raw_c;

    assign p0_c = scale_prod(x,      C0, FRAC);
    assign p1_c = scale_prod(x_d1_q, C1, FRAC);
    assign p2_c = scale_prod(x_d2_q, C2, FRAC);

    // Summation order is fixed: (p0 + p1) first, then + p2.
    approx_add16 #(.APPROX_LSBS(APPROX_LSBS)) u_add0 (
        .a (p0_c),
        .b (p1_c),
        .s (s1_raw_c)
    );

    assign s1_c = sat16(PROD_W'(s1_raw_c));

    approx_add16 #(.APPROX_LSBS(APPROX_LSBS)) u_add1 (
        .a (s1_c),
        .b (p2_c),
        .s (s2_raw_c)
    );

    assign y_d = sat16(PROD_W'(s2_raw_c));

    // rstN is active-high despite its name.
    always_ff @(posedge clk or posedge rstN) begin
        if (rstN) begin
            x_d1_q <= '0;
            x_d2_q <= '0;
            y_q    <= '0;
        end else begin
            x_d1_q <= x;
            x_d2_q <= x_d1_q;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: tb/tb_fir3_tap.sv
// Directed-vector and random bench for fir3_tap: default, exact-adder and saturating builds.
module tb_fir3_tap;
    import fir3_tap_pkg::*;

    logic    clk;
    logic    rstN;
    sample_t x;
    sample_t y;
    sample_t y_ex;
    sample_t y_sat;

    int n_checks;
    int n_fail;

    fir3_tap dut (
        .clk  (clk),
        .rstN (rstN),
        .x    (x),
        .y    (y)
    );

    fir3_tap #(.APPROX_LSBS(0)) dut_ex (
        .clk  (clk),
        .rstN (rstN),
        .x    (x),
        .y    (y_ex)
    );

    fir3_tap #(.C0(16'sd4), .C1(16'sd4), .C2(16'sd4), .FRAC(0)) dut_sat (
        .clk  (clk),
        .rstN (rstN),
        .x    (x),
        .y    (y_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        int         xv;
        int         y_exp;
        int         yex_exp;
        int         ysat_exp;
        logic [2:0] chk;   // bit0 dut, bit1 dut_ex, bit2 dut_sat
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_sat(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int m_prod(input int xv, input int c, input int frac);
        return m_sat((xv * c) >>> frac);
    endfunction

    // Reference approximate adder written in plain integer arithmetic.
    function automatic int m_add(input int a, input int b, input int k);
        int low;
        int cin;
        int hi;
        if (k == 0) return a + b;
        low = (a | b) & ((1 << k) - 1);
        cin = ((a >>> (k - 1)) & 1) & ((b >>> (k - 1)) & 1);
        hi  = (a >>> k) + (b >>> k) + cin;
        return hi * (1 << k) + low;
    endfunction

    function automatic int m_fir(input int x0, input int x1, input int x2,
                                 input int c0, input int c1, input int c2,
                                 input int frac, input int k);
        int s1;
        s1 = m_sat(m_add(m_prod(x0, c0, frac), m_prod(x1, c1, frac), k));
        return m_sat(m_add(s1, m_prod(x2, c2, frac), k));
    endfunction

    initial begin
        int h1;
        int h2;
        int xi;
        int ex;
        real sq_err;
        sample_t xs;

        n_checks = 0;
        n_fail   = 0;
        rstN     = 1'b1;
        x        = '0;

        // rst, x, y(default), y(exact adder), y(saturating build), check mask
        tbl.push_back('{1'b1,  1234,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b1,     0,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b1,  1234,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b0,   400,  100,  100,   1600, 3'b111});
        tbl.push_back('{1'b0,     0,  200,  200,   1600, 3'b111});
        tbl.push_back('{1'b0,     0,  100,  100,   1600, 3'b111});
        tbl.push_back('{1'b0,     0,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b0,     0,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b0,  -400, -100, -100,  -1600, 3'b111});
        tbl.push_back('{1'b0,     0, -200, -200,  -1600, 3'b111});
        tbl.push_back('{1'b0,     0, -100, -100,  -1600, 3'b111});
        tbl.push_back('{1'b0,     0,    0,    0,      0, 3'b111});
        tbl.push_back('{1'b0,   400,  100,  100,   1600, 3'b111});
        tbl.push_back('{1'b0,   400,  300,  300,   3200, 3'b111});
        tbl.push_back('{1'b0,   400,  396,  400,   4800, 3'b111});
        tbl.push_back('{1'b0,   400,  396,  400,   4800, 3'b111});
        tbl.push_back('{1'b0, 20000,    0,    0,  32767, 3'b100});
        tbl.push_back('{1'b0, 20000,    0,    0,  32767, 3'b100});
        tbl.push_back('{1'b0, 20000,    0,    0,  32767, 3'b100});
        tbl.push_back('{1'b0,-20000,    0,    0,  32767, 3'b100});
        tbl.push_back('{1'b0,-20000,    0,    0,     -1, 3'b100});
        tbl.push_back('{1'b0,-20000,    0,    0, -32768, 3'b100});
        tbl.push_back('{1'b0,-20000,    0,    0, -32768, 3'b100});

        #1;
        check("reset_y_t0", int'(y), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rstN = tbl[i].rst;
            x    = 16'(tbl[i].xv);
            @(posedge clk);
            #1;
            if (tbl[i].chk[0]) check($sformatf("vec%0d_y", i), int'(y), tbl[i].y_exp);
            if (tbl[i].chk[1]) check($sformatf("vec%0d_y_ex", i), int'(y_ex), tbl[i].yex_exp);
            if (tbl[i].chk[2]) check($sformatf("vec%0d_y_sat", i), int'(y_sat), tbl[i].ysat_exp);
        end

        // Mid-stream asynchronous reset between clock edges.
        x = 16'sd400;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("steady_before_rst", int'(y), 396);
        #2;
        rstN = 1'b1;
        #1;
        check("async_clear_y", int'(y), 0);
        check("async_clear_y_ex", int'(y_ex), 0);
        check("async_clear_y_sat", int'(y_sat), 0);
        @(posedge clk);
        #1;
        check("rst_held_y", int'(y), 0);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_y0", int'(y), 100);
        @(posedge clk);
        #1;
        check("post_rst_y1", int'(y), 300);
        @(posedge clk);
        #1;
        check("post_rst_y2", int'(y), 396);

        // Random stream against the bit-exact reference.
        rstN = 1'b1;
        @(posedge clk);
        #1;
        rstN = 1'b0;
        h1 = 0;
        h2 = 0;
        sq_err = 0.0;
        for (int n = 0; n < 10000; n++) begin
            xs = 16'($urandom());
            xi = int'(xs);
            x  = xs;
            @(posedge clk);
            #1;
            check("rand_y", int'(y), m_fir(xi, h1, h2, 1, 2, 1, 2, 4));
            check("rand_y_ex", int'(y_ex), m_fir(xi, h1, h2, 1, 2, 1, 2, 0));
            check("rand_y_sat", int'(y_sat), m_fir(xi, h1, h2, 4, 4, 4, 0, 4));
            ex = m_sat(m_prod(xi, 1, 2) + m_prod(h1, 2, 2) + m_prod(h2, 1, 2));
            sq_err += real'((int'(y) - ex) * (int'(y) - ex));
            h2 = h1;
            h1 = xi;
        end
        $display("MSE of approximate filter vs exact filter over 10000 samples: %f",
                 sq_err / 10000.0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
